// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nibble_serial_adder_pkg;

    // Width of the one combinational adder slice reused every cycle.
    localparam int NIBBLE_W = 4;

    // Operation FSM; the encodings are shared with the rest of the ALU.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_nibble_adder.sv
// Combinational 4-bit adder slice with carry in and carry out.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the slice has no handshake.
module nibble_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s4,
    output logic                cout
);

    logic [NIBBLE_W:0] total;

    // Zero-extend every operand so the fifth bit captures the carry.
    assign total = {1'b0, a4} + {1'b0, b4} + {{NIBBLE_W{1'b0}}, cin};
    assign s4    = total[NIBBLE_W-1:0];
    assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a registered-carry slice.
// Latency: WIDTH/4 edges from the accepting edge to the done pulse.
// Backpressure: start is honoured only in IDLE or DONE; start during RUN is dropped.
// Optional overflow output is built when ADDER_OVF_FLAG_EN is defined.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef ADDER_OVF_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [IDX_W-1:0]    idx;
    logic                carry_q;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                c_nib;
    logic                accept;
    logic                last;

    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last   = (state == ST_RUN) && (idx == LAST_IDX);

    // The index counter steers the single slice across the latched operands.
    assign a_nib = a_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[int'(idx)*NIBBLE_W +: NIBBLE_W];

    nibble_adder u_slice (
        .a4   (a_nib),
        .b4   (b_nib),
        .cin  (carry_q),
        .s4   (s_nib),
        .cout (c_nib)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs; DONE lasts one cycle so done is a pulse.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one nibble of sum and the carry per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_q       <= a;
            b_q       <= b;
            carry_q   <= carry_in;
            idx       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (state == ST_RUN) begin
            sum[int'(idx)*NIBBLE_W +: NIBBLE_W] <= s_nib;
            carry_q <= c_nib;
            idx     <= last ? '0 : idx + 1'b1;
            if (last) carry_out <= c_nib;
        end
    end

`ifdef ADDER_OVF_FLAG_EN
    // Signed overflow: like-signed operands whose result flips sign.
    // The top sum bit is taken from the slice output being written this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (accept) begin
            overflow <= 1'b0;
        end else if (last) begin
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (s_nib[NIBBLE_W-1] != a_q[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): directed cases then random operations.
// Reference model is plain integer addition with masking for partial results.
// Overflow is checked when ADDER_OVF_FLAG_EN is defined.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;
`ifdef ADDER_OVF_FLAG_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (ci),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (co)
`ifdef ADDER_OVF_FLAG_EN
        ,
        .overflow  (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required summary before limit");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_full(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Sum visible after k processed nibbles: low 4k bits of the true sum, rest zero.
    function automatic logic [W-1:0] ref_partial(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic c, input int k);
        logic [W:0]   full;
        logic [W-1:0] mask;
        full = ref_full(x, y, c);
        mask = (k >= N) ? {W{1'b1}} : W'((32'd1 << (4 * k)) - 32'd1);
        return full[W-1:0] & mask;
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] full;
        full = ref_full(x, y, c);
        return (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    endfunction

    // Drive a request for one cycle, then scramble the operand inputs.
    task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        start = 1'b1;
        a     = xa;
        b     = xb;
        ci    = xc;
        step();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        ci    = 1'($urandom_range(0, 1));
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_done", 32'(done), 32'd0);
        chk("accept_sum",  32'(sum),  32'd0);
    endtask

    // Walk the RUN cycles; optionally pulse start with junk operands mid-run.
    task automatic finish_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                             input bit glitch);
        logic [W:0] full;
        full = ref_full(xa, xb, xc);
        for (int k = 1; k <= N; k++) begin
            if (glitch && k == 2) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                ci    = 1'($urandom_range(0, 1));
            end
            step();
            start = 1'b0;
            if (k < N) begin
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_done", 32'(done), 32'd0);
                chk("run_sum",  32'(sum),  32'(ref_partial(xa, xb, xc, k)));
            end else begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_busy",  32'(busy), 32'd0);
                chk("done_sum",   32'(sum),  32'(full[W-1:0]));
                chk("done_co",    32'(co),   32'(full[W]));
`ifdef ADDER_OVF_FLAG_EN
                chk("done_ovf",   32'(ovf),  32'(ref_ovf(xa, xb, xc)));
`endif
            end
        end
    endtask

    // One cycle after done: pulse gone, results held.
    task automatic idle_check(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        logic [W:0] full;
        full = ref_full(xa, xb, xc);
        step();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sum",  32'(sum),  32'(full[W-1:0]));
        chk("idle_co",   32'(co),   32'(full[W]));
`ifdef ADDER_OVF_FLAG_EN
        chk("idle_ovf",  32'(ovf),  32'(ref_ovf(xa, xb, xc)));
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sum"},  32'(sum),  32'd0);
        chk({tag, "_co"},   32'(co),   32'd0);
`ifdef ADDER_OVF_FLAG_EN
        chk({tag, "_ovf"},  32'(ovf),  32'd0);
`endif
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        bit           gl;

        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        ci    = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("reset");
        #10 rst_n = 1'b1;

        // Basic add, latency and busy span.
        launch(16'h1234, 16'h4321, 1'b0);
        finish_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        idle_check(16'h1234, 16'h4321, 1'b0);

        // Wrap with carry out, and carry-in only.
        launch(16'hFFFF, 16'h0001, 1'b0);
        finish_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle_check(16'hFFFF, 16'h0001, 1'b0);
        launch(16'h0000, 16'h0000, 1'b1);
        finish_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        idle_check(16'h0000, 16'h0000, 1'b1);

        // Signed overflow corners.
        launch(16'h7FFF, 16'h0001, 1'b0);
        finish_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        idle_check(16'h7FFF, 16'h0001, 1'b0);
        launch(16'h8000, 16'h8000, 1'b0);
        finish_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        idle_check(16'h8000, 16'h8000, 1'b0);

        // start during RUN is ignored.
        launch(16'h1234, 16'h4321, 1'b0);
        finish_op(16'h1234, 16'h4321, 1'b0, 1'b1);
        idle_check(16'h1234, 16'h4321, 1'b0);

        // Reset asserted mid-operation, just ahead of E2.
        launch(16'h1234, 16'h4321, 1'b0);
        step();
        chk("pre_rst_sum", 32'(sum), 32'h0005);
        #3 rst_n = 1'b0;
        #1 check_zero("midrst");
        step();
        check_zero("rst_hold");
        #3 rst_n = 1'b1;
        launch(16'hA5A5, 16'h5A5B, 1'b0);
        finish_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
        idle_check(16'hA5A5, 16'hA5A5 ^ 16'hFFFE, 1'b0);

        // Back-to-back: start asserted during the DONE cycle.
        launch(16'h0F0F, 16'h00F1, 1'b1);
        finish_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        launch(16'hC001, 16'h4FFF, 1'b0);
        finish_op(16'hC001, 16'h4FFF, 1'b0, 1'b0);
        idle_check(16'hC001, 16'h4FFF, 1'b0);

        // Random operations, mixing back-to-back, idle gaps and mid-run start pulses.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            gl = 1'($urandom_range(0, 1));
            launch(ra, rb, rc);
            finish_op(ra, rb, rc, gl);
            if ($urandom_range(0, 1) == 1) idle_check(ra, rb, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
